// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// EX opcode encodings, controller state encodings and default limits.
package hilo_muldiv_ctrl_pkg;

  localparam int unsigned OP_W_DEF     = 3;
  localparam logic [5:0]  MAX_WAIT_DEF = 6'd40;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } ex_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_CAPTURE
  } state_e;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Handshake bundle between the HI/LO controller and the mul/div units.
//   mul_start/div_start   : start/hold request, held until ready
//   mul_signed/div_signed : signed operation
//   mul_a/b, div_a/b      : latched operands, stable while start is high
//   mul_annul/div_annul   : one-cycle cancel pulse
//   mul_ready/div_ready   : unit result valid
//   mul_result            : {hi,lo} product
//   div_result            : {remainder,quotient}
// master = controller side, slave = execution unit side.
interface hilo_muldiv_ctrl_if;
  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_annul;
  logic        mul_ready;
  logic [63:0] mul_result;

  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;

  modport master (
    output mul_start, mul_signed, mul_a, mul_b, mul_annul,
    input  mul_ready, mul_result,
    output div_start, div_signed, div_a, div_b, div_annul,
    input  div_ready, div_result
  );

  modport slave (
    input  mul_start, mul_signed, mul_a, mul_b, mul_annul,
    output mul_ready, mul_result,
    input  div_start, div_signed, div_a, div_b, div_annul,
    output div_ready, div_result
  );
endinterface

// File: rtl/hilo_muldiv_ctrl_hilo_regfile.sv
// Architectural HI/LO storage.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_hi/lo   : MTHI/MTLO write strobes, data from wr_data
//   cap_en     : 64-bit capture of cap_data into {hi,lo}
//   hi, lo     : register outputs
module hilo_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  input  logic        cap_en,
  input  logic [63:0] cap_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (cap_en) begin
      hi <= cap_data[63:32];
      lo <= cap_data[31:0];
    end else begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage initiator for the multiply/divide units. Decodes MULT/MULTU/
// DIV/DIVU/MTHI/MTLO, launches the selected unit, stalls the pipeline until
// it reports ready, captures the 64-bit result into HI/LO, and annuls an
// in-flight operation on flush.
//   clk, rst            : clock, asynchronous active-high reset
//   ex_valid/op/a/b     : instruction and operands held in EX
//   ex_flush            : flush of EX
//   pipe_enable         : downstream advance (informational only)
//   mdu                 : mul/div handshake bundle (master side)
//   stall_req           : freeze IF/ID/EX
//   hi, lo              : architectural HI/LO
//   timeout             : sticky, a unit exceeded MAX_WAIT cycles
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter logic [5:0]  MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned OP_W     = OP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [OP_W-1:0]    ex_op,
  input  logic [31:0]        ex_a,
  input  logic [31:0]        ex_b,
  input  logic               ex_flush,
  input  logic               pipe_enable,
  hilo_muldiv_ctrl_if.master mdu,
  output logic               stall_req,
  output logic [31:0]        hi,
  output logic [31:0]        lo,
  output logic               timeout
);

  state_e      state, state_next;
  logic [2:0]  op;
  logic        launch_mul, launch_div;
  logic        wr_hi, wr_lo, capture;
  logic        waiting, unit_ready;
  logic        cap_div;
  logic [5:0]  wait_cnt, cnt_inc;
  logic [63:0] cap_data;
  logic        unused_pipe_enable;

  assign op = 3'(ex_op);

  // HI/LO are written in CAPTURE regardless of downstream advance; holding
  // the instruction is left to the hazard unit.
  assign unused_pipe_enable = pipe_enable;

  assign waiting    = (state == S_MUL_WAIT) || (state == S_DIV_WAIT);
  assign unit_ready = (state == S_MUL_WAIT) ? mdu.mul_ready : mdu.div_ready;
  assign cnt_inc    = wait_cnt + 6'd1;
  assign cap_data   = cap_div ? mdu.div_result : mdu.mul_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    launch_mul = 1'b0;
    launch_div = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ex_valid && !ex_flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              launch_mul = 1'b1;
              stall_req  = 1'b1;
              state_next = S_MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              launch_div = 1'b1;
              stall_req  = 1'b1;
              state_next = S_DIV_WAIT;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL_WAIT, S_DIV_WAIT: begin
        stall_req = 1'b1;
        // Flush takes priority over a coincident ready: no capture.
        if (ex_flush)        state_next = S_IDLE;
        else if (unit_ready) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu.mul_start  <= 1'b0;
      mdu.mul_signed <= 1'b0;
      mdu.mul_a      <= '0;
      mdu.mul_b      <= '0;
      mdu.mul_annul  <= 1'b0;
      mdu.div_start  <= 1'b0;
      mdu.div_signed <= 1'b0;
      mdu.div_a      <= '0;
      mdu.div_b      <= '0;
      mdu.div_annul  <= 1'b0;
      cap_div        <= 1'b0;
      wait_cnt       <= '0;
      timeout        <= 1'b0;
    end else begin
      mdu.mul_annul <= 1'b0;
      mdu.div_annul <= 1'b0;
      if (launch_mul) begin
        mdu.mul_a      <= ex_a;
        mdu.mul_b      <= ex_b;
        mdu.mul_signed <= (op == OP_MULT);
        mdu.mul_start  <= 1'b1;
        cap_div        <= 1'b0;
        wait_cnt       <= '0;
      end
      if (launch_div) begin
        mdu.div_a      <= ex_a;
        mdu.div_b      <= ex_b;
        mdu.div_signed <= (op == OP_DIV);
        mdu.div_start  <= 1'b1;
        cap_div        <= 1'b1;
        wait_cnt       <= '0;
      end
      if (waiting) begin
        if (ex_flush) begin
          mdu.mul_annul <= (state == S_MUL_WAIT);
          mdu.div_annul <= (state == S_DIV_WAIT);
          mdu.mul_start <= 1'b0;
          mdu.div_start <= 1'b0;
          wait_cnt      <= '0;
        end else begin
          // Saturated counter never re-triggers; timeout is sticky anyway.
          if (wait_cnt != '1 && cnt_inc == MAX_WAIT) timeout <= 1'b1;
          if (unit_ready) begin
            mdu.mul_start <= 1'b0;
            mdu.div_start <= 1'b0;
            wait_cnt      <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= cnt_inc;
          end
        end
      end
    end
  end

  hilo_regfile u_hilo (
    .clk      (clk),
    .rst      (rst),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wr_data  (ex_a),
    .cap_en   (capture),
    .cap_data (cap_data),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: table of mul/div transactions
// with a result scoreboard, plus hand-written flush, timeout and reset cases.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned lat;
    logic        sgn;
    logic        pe;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_flush;
  logic        pipe_enable;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout;

  int          n_cmp;
  int          n_bad;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;
  vec_t        vecs[8];
  vec_t        vx;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(.MAX_WAIT(6'd40), .OP_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_flush    (ex_flush),
    .pipe_enable (pipe_enable),
    .mdu         (bus),
    .stall_req   (stall_req),
    .hi          (hi),
    .lo          (lo),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mul/div units computing from the latched operands.
  logic [63:0] mul_res;
  logic [63:0] div_res;
  always_comb begin
    if (bus.mul_signed)
      mul_res = $signed({{32{bus.mul_a[31]}}, bus.mul_a}) * $signed({{32{bus.mul_b[31]}}, bus.mul_b});
    else
      mul_res = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
    div_res = '1;
    if (bus.div_b != 32'd0) begin
      if (bus.div_signed)
        div_res = {32'($signed(bus.div_a) % $signed(bus.div_b)),
                   32'($signed(bus.div_a) / $signed(bus.div_b))};
      else
        div_res = {bus.div_a % bus.div_b, bus.div_a / bus.div_b};
    end
  end
  assign bus.mul_result = mul_res;
  assign bus.div_result = div_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_capture();
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL capture_queue: got empty scoreboard, required one pending result");
    end else begin
      e = exp_q.pop_front();
      check("hi", 64'(hi), 64'(e[63:32]));
      check("lo", 64'(lo), 64'(e[31:0]));
      cur_hi = e[63:32];
      cur_lo = e[31:0];
    end
  endtask

  task automatic run_op(input vec_t v);
    int unsigned stalls;
    int unsigned c;
    logic        ok_hold;
    logic        is_div;
    is_div  = (v.op == OP_DIV) || (v.op == OP_DIVU);
    stalls  = 0;
    c       = 0;
    ok_hold = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = v.op; ex_a = v.a; ex_b = v.b; ex_flush = 1'b0;
    pipe_enable = v.pe;
    exp_q.push_back({v.hi, v.lo});
    while (c < v.lat + 8) begin
      bus.mul_ready = !is_div && (c == v.lat);
      bus.div_ready = is_div && (c == v.lat);
      @(negedge clk);
      if (!stall_req) break;
      stalls++;
      if (c > 0) begin
        if (is_div)
          ok_hold &= bus.div_start && (bus.div_a == v.a) && (bus.div_b == v.b) &&
                     (bus.div_signed == v.sgn) && !bus.mul_start;
        else
          ok_hold &= bus.mul_start && (bus.mul_a == v.a) && (bus.mul_b == v.b) &&
                     (bus.mul_signed == v.sgn) && !bus.div_start;
      end
      @(posedge clk); #1;
      c++;
    end
    bus.mul_ready = 1'b0;
    bus.div_ready = 1'b0;
    check("stall_cycles", 64'(stalls), 64'(v.lat + 1));
    check("launch_hold", 64'(ok_hold), 64'(1));
    check("start_drop", 64'(is_div ? bus.div_start : bus.mul_start), 64'(0));
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = OP_NOP; pipe_enable = 1'b1;
    @(negedge clk);
    expect_capture();
    check("no_stall_after", 64'(stall_req), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; ex_valid = 1'b0; ex_op = OP_NOP; ex_a = '0; ex_b = '0;
    ex_flush = 1'b0; pipe_enable = 1'b1;
    bus.mul_ready = 1'b0; bus.div_ready = 1'b0;
    cur_hi = '0; cur_lo = '0;

    //            op        a             b             lat sgn pe  hi            lo
    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 2, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{OP_DIVU,  32'd100,      32'd7,        3, 1'b0, 1'b1, 32'd2,        32'd14};
    vecs[2] = '{OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 1, 1'b0, 1'b1, 32'h00000002, 32'hFFFFFFFA};
    vecs[3] = '{OP_DIV,   32'hFFFFFF9C, 32'd7,        4, 1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFF2};
    vecs[4] = '{OP_MULTU, 32'h00010000, 32'h00010000, 5, 1'b0, 1'b0, 32'h00000001, 32'h00000000};
    vecs[5] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 2, 1'b0, 1'b1, 32'h0000000F, 32'h0FFFFFFF};
    vecs[6] = '{OP_MULT,  32'h80000000, 32'h00000002, 1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000};
    vecs[7] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 2, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFD};

    // Reset state
    @(posedge clk); #1;
    check("rst_stall", 64'(stall_req), 64'(0));
    check("rst_starts", 64'({bus.mul_start, bus.div_start, bus.mul_annul, bus.div_annul}), 64'(0));
    check("rst_operands", {bus.mul_a | bus.mul_b, bus.div_a | bus.div_b}, 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // MTHI then MTLO back to back
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = OP_MTHI; ex_a = 32'h12345678;
    @(negedge clk);
    check("mthi_no_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    ex_op = OP_MTLO; ex_a = 32'h9ABCDEF0;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_lo_kept", 64'(lo), 64'(cur_lo));
    check("mtlo_no_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = OP_NOP;
    @(negedge clk);
    check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
    check("mtlo_hi_kept", 64'(hi), 64'h12345678);
    cur_hi = 32'h12345678; cur_lo = 32'h9ABCDEF0;

    // Flush on wait cycle 2
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = OP_MULT; ex_a = 32'd5; ex_b = 32'd7;
    @(negedge clk);
    check("flush_issue_stall", 64'(stall_req), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_w1_start", 64'(bus.mul_start), 64'(1));
    @(posedge clk); #1;
    ex_flush = 1'b1;
    @(negedge clk);
    check("flush_w2_stall", 64'(stall_req), 64'(1));
    check("flush_w2_no_annul", 64'(bus.mul_annul), 64'(0));
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_valid = 1'b0; ex_op = OP_NOP;
    @(negedge clk);
    check("flush_annul", 64'(bus.mul_annul), 64'(1));
    check("flush_div_annul", 64'(bus.div_annul), 64'(0));
    check("flush_start_low", 64'(bus.mul_start), 64'(0));
    check("flush_idle_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_annul_pulse", 64'(bus.mul_annul), 64'(0));
    check("flush_hilo_kept", {hi, lo}, {cur_hi, cur_lo});
    vx = '{OP_MULT, 32'hFFFFFFFD, 32'd7, 3, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
    run_op(vx);

    // Flush coincident with mul_ready
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = OP_MULTU; ex_a = 32'd9; ex_b = 32'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mul_ready = 1'b1; ex_flush = 1'b1;
    @(posedge clk); #1;
    bus.mul_ready = 1'b0; ex_flush = 1'b0; ex_valid = 1'b0; ex_op = OP_NOP;
    @(negedge clk);
    check("coincide_no_stall", 64'(stall_req), 64'(0));
    check("coincide_annul", 64'(bus.mul_annul), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("coincide_hilo_kept", {hi, lo}, {cur_hi, cur_lo});
    check("coincide_stall_idle", 64'(stall_req), 64'(0));

    // Flush in IDLE with a new op, plus ready while idle
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = OP_DIV; ex_a = 32'd50; ex_b = 32'd5; ex_flush = 1'b1;
    bus.mul_ready = 1'b1; bus.div_ready = 1'b1;
    @(negedge clk);
    check("idle_flush_no_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = OP_NOP; ex_flush = 1'b0;
    @(negedge clk);
    check("idle_flush_no_launch", 64'({bus.div_start, bus.mul_start}), 64'(0));
    @(posedge clk); #1;
    bus.mul_ready = 1'b0; bus.div_ready = 1'b0;
    @(negedge clk);
    check("idle_ready_ignored", {hi, lo}, {cur_hi, cur_lo});

    // DIVU 81/8 with ready withheld 45 cycles: timeout at wait cycle 40
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = OP_DIVU; ex_a = 32'd81; ex_b = 32'd8;
    exp_q.push_back({32'd1, 32'd10});
    for (int c = 0; c <= 46; c++) begin
      bus.div_ready = (c == 46);
      @(negedge clk);
      if (c == 30) check("long_wait_stall", 64'(stall_req), 64'(1));
      if (c == 40) check("timeout_before", 64'(timeout), 64'(0));
      if (c == 41) check("timeout_set", 64'(timeout), 64'(1));
      if (c == 45) check("long_wait_operands", {bus.div_a, bus.div_b}, {32'd81, 32'd8});
      @(posedge clk); #1;
    end
    bus.div_ready = 1'b0;
    @(negedge clk);
    check("long_capture_no_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = OP_NOP;
    @(negedge clk);
    expect_capture();
    check("timeout_sticky", 64'(timeout), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("rst_clears_timeout", 64'(timeout), 64'(0));
    check("rst_clears_hilo", {hi, lo}, 64'(0));
    cur_hi = '0; cur_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of an operation
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = OP_MULT; ex_a = 32'd3; ex_b = 32'd3;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_pre_start", 64'(bus.mul_start), 64'(1));
    #1 rst = 1'b1; ex_valid = 1'b0; ex_op = OP_NOP;
    #1;
    check("midrst_start", 64'(bus.mul_start), 64'(0));
    check("midrst_stall", 64'(stall_req), 64'(0));
    check("midrst_annul", 64'({bus.mul_annul, bus.div_annul}), 64'(0));
    check("midrst_operands", {bus.mul_a, bus.mul_b}, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    vx = '{OP_MULTU, 32'd6, 32'd7, 2, 1'b0, 1'b1, 32'd0, 32'd42};
    run_op(vx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Initiator side of the EX-stage multiply/divide handshake. Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, launches the multiplier or divider, and stalls the pipeline until the unit reports ready.
- Captures the 64-bit result into architectural HI/LO registers.
- Cancels an in-flight operation on pipeline flush.
- Sits between the EX stage, the hazard/stall unit, and the mul/div execution units.

Parameters:
- MAX_WAIT, 6'd40: cycles allowed between start and ready before the timeout flag sets.
- OP_W, 3: width of the ex_op encoding.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX holds a valid instruction
- ex_op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
- ex_a  in  32  rs operand
- ex_b  in  32  rt operand
- ex_flush  in  1  exception/branch flush of EX
- pipe_enable  in  1  downstream stages advancing this cycle
- mul_start  out  1  start/hold request to multiplier
- mul_signed  out  1  signed operation
- mul_a, mul_b  out  32 each  latched operands
- mul_annul  out  1  cancel pulse to multiplier
- mul_ready  in  1  multiplier result valid
- mul_result  in  64  {hi,lo} product
- div_start, div_signed, div_a, div_b, div_annul  out  as mul_*
- div_ready  in  1  divider result valid
- div_result  in  64  {remainder,quotient}
- stall_req  out  1  freeze IF/ID/EX
- hi, lo  out  32 each  architectural HI/LO
- timeout  out  1  sticky: unit exceeded MAX_WAIT

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; operand latches 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, CAPTURE.
- IDLE:
  - ex_valid & op 1/2 & !ex_flush: latch ex_a/ex_b into mul_a/mul_b; mul_signed = (op==1); assert mul_start; go to MUL_WAIT. stall_req is asserted combinationally in this same cycle.
  - Op 3/4: same on the div_* ports, go to DIV_WAIT.
  - Op 5/6: write hi (5) or lo (6) from ex_a on the same edge; no stall.
- MUL_WAIT / DIV_WAIT:
  - start held high and operands held stable.
  - Counter increments each cycle; stall_req = 1.
  - On ready=1: go to CAPTURE.
- CAPTURE, one cycle:
  - {hi,lo} <= mul_result, or {lo,hi} <= {quotient,remainder} for div.
  - Drop start; deassert stall_req; return to IDLE.
  - Issue-to-writeback latency = unit latency + 1 cycle.
- Start is never reasserted for the same instruction. The instruction leaves EX only after CAPTURE.
- If pipe_enable=0 in CAPTURE: HI/LO are still written. stall_req stays low; holding is the hazard unit's job.
- ex_flush in MUL_WAIT/DIV_WAIT:
  - One-cycle annul pulse on the active unit; start=0; counter clears; IDLE next cycle.
  - HI/LO unchanged.
- ex_flush in the same cycle as ready: flush wins; HI/LO unchanged.
- ex_flush in IDLE with a new mul/div op: no launch.
- Counter reaching MAX_WAIT: timeout sets and stays set until reset; the wait continues.
- Counter saturates at its maximum; no wrap.
- rst mid-operation: everything returns to reset values immediately. No annul is issued; units are reset by the same rst.
- Unexpected ready while IDLE: ignored.

Decomposition:
- Shared package:
  - ex_op encodings (OP_NOP..OP_MTLO)
  - state encodings
  - MAX_WAIT default
- One natural sub-module: hilo_regfile (HI/LO storage, MTHI/MTLO write, 64-bit capture).
- FSM, launch and annul logic stay in this module.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003, mul_ready 2 cycles after start:
  - stall_req high for exactly 3 cycles.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - mul_start falls the cycle after ready.
- DIVU 100 / 7:
  - div_signed=0.
  - After div_ready: lo=14, hi=2.
  - Operands stable on div_a/div_b throughout the wait.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back: no stall; hi/lo update on consecutive edges.
- MULT launched, ex_flush on cycle 2 of the wait:
  - mul_annul pulses for one cycle; state IDLE next cycle.
  - hi/lo keep their previous values.
  - A later MULT completes normally.
- ex_flush coincident with mul_ready: no HI/LO write, no stall afterwards.
- DIV with div_ready withheld for 45 cycles:
  - timeout sets at wait cycle 40 and stays set after the result is captured.
  - rst clears timeout, hi and lo to 0.
